// File: rtl/sfft_reader_pkg.sv
// Shared constants and types for the SFFT frame reader.
// No logic; pure declarations.
// No flow control involved.
package sfft_reader_pkg;

   localparam int DFLT_N_POINTS   = 256;
   localparam int DFLT_DATA_WIDTH = 24;
   localparam int DFLT_CNT_WIDTH  = 16;

   typedef logic [DFLT_DATA_WIDTH-1:0] spectrum_word_t;

   // Capture FSM: WAIT for a frame, CAPTURED pulses idle low, DRAIN waits for valid to drop
   typedef enum logic [1:0] {
      WAIT     = 2'd0,
      CAPTURED = 2'd1,
      DRAIN    = 2'd2
   } capState_t;

endpackage

// File: rtl/sfft_frame_bank.sv
// One frame buffer: whole-frame parallel write, single word read port.
// Read latency 1 cycle (registered rdData); write lands on the enabling edge.
// No backpressure; the owner decides when to write and read.
module sfft_frame_bank #(
   parameter int N_POINTS   = 256,
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = $clog2(N_POINTS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wrEn,
   input  logic [DATA_WIDTH-1:0] wrData [N_POINTS],
   input  logic                  rdEn,
   input  logic [ADDR_WIDTH-1:0] rdAddr,
   output logic [DATA_WIDTH-1:0] rdData
);

   logic [DATA_WIDTH-1:0] mem [N_POINTS];

   // Latch a complete frame in one edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_POINTS; i++) mem[i] <= '0;
      end else if (wrEn) begin
         for (int i = 0; i < N_POINTS; i++) mem[i] <= wrData[i];
      end
   end

   // Registered word read; holds last value when not reading
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rdData <= '0;
      else if (rdEn)  rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/sfft_frame_reader.sv
// Captures SFFT output frames into two banks and serves them word by word (build macro SFFT_READER_OVERWRITE_EN).
// Capture on the edge valid is seen; idle drops the next cycle; read data 1 cycle after rd_req.
// With a frame pending the pipeline is stalled via idle=1, unless SFFT_READER_OVERWRITE_EN replaces it.
module sfft_frame_reader
   import sfft_reader_pkg::*;
#(
   parameter int N_POINTS   = DFLT_N_POINTS,
   parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(N_POINTS),
   parameter int CNT_WIDTH  = DFLT_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sfft_in [N_POINTS],
   input  logic                  sfft_valid,
   output logic                  idle,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  frame_ready,
   input  logic                  frame_ack,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic [CNT_WIDTH-1:0]  overrun_count
);

   capState_t state;
   logic      readBank;
   logic      pending;
   logic      rdSel;
   logic      latch;

   // Ack is resolved first so a capture in the same cycle sees the post-ack view
   logic ackHit;
   logic ackSwap;
   logic readyAfterAck;
   logic pendingAfterAck;
   logic bankAfterAck;
   logic writeBank;

   logic                  readBankNext;
   logic                  readyNext;
   logic                  pendingNext;
   logic [DATA_WIDTH-1:0] rdData0;
   logic [DATA_WIDTH-1:0] rdData1;

   assign ackHit          = frame_ack & frame_ready;
   assign ackSwap         = ackHit & pending;
   assign readyAfterAck   = frame_ready & ~(ackHit & ~pending);
   assign pendingAfterAck = pending & ~ackHit;
   assign bankAfterAck    = readBank ^ ackSwap;
   assign writeBank       = ~bankAfterAck;

`ifdef SFFT_READER_OVERWRITE_EN
   // A capture is never blocked; an unread pending frame gets replaced
   assign latch = (state == WAIT) & sfft_valid;
`else
   // Registered pending blocks capture until the reader frees a bank
   assign latch = (state == WAIT) & sfft_valid & ~pending;
`endif

   // Capture FSM; idle is registered so it falls the cycle after the latch edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= WAIT;
         idle  <= 1'b1;
      end else begin
         idle <= ~latch;
         case (state)
            WAIT:     if (latch) state <= CAPTURED;
            CAPTURED: state <= DRAIN;
            DRAIN:    if (!sfft_valid) state <= WAIT;
            default:  state <= WAIT;
         endcase
      end
   end

   // Bank ownership: ack first, then a capture either publishes or parks the new frame
   always_comb begin
      readBankNext = bankAfterAck;
      readyNext    = readyAfterAck;
      pendingNext  = pendingAfterAck;
      if (latch) begin
         if (!readyAfterAck) begin
            readBankNext = writeBank;
            readyNext    = 1'b1;
         end else begin
            pendingNext  = 1'b1;
         end
      end
   end

   // Bank ownership registers and the wrapping frame counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readBank    <= 1'b0;
         frame_ready <= 1'b0;
         pending     <= 1'b0;
         frame_count <= '0;
      end else begin
         readBank    <= readBankNext;
         frame_ready <= readyNext;
         pending     <= pendingNext;
         if (latch) frame_count <= frame_count + CNT_WIDTH'(1);
      end
   end

`ifdef SFFT_READER_OVERWRITE_EN
   logic overrun;
   assign overrun = latch & pendingAfterAck;

   // Saturating count of pending frames that were replaced before being read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overrun_count <= '0;
      else if (overrun && (overrun_count != '1))
         overrun_count <= overrun_count + CNT_WIDTH'(1);
   end
`else
   assign overrun_count = '0;
`endif

   // Remember which bank each request addressed so a later swap cannot redirect it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdSel    <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) rdSel <= readBank;
      end
   end

   assign rd_data = rdSel ? rdData1 : rdData0;

   sfft_frame_bank #(
      .N_POINTS   (N_POINTS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) bank0 (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (latch & ~writeBank),
      .wrData (sfft_in),
      .rdEn   (rd_req),
      .rdAddr (rd_addr),
      .rdData (rdData0)
   );

   sfft_frame_bank #(
      .N_POINTS   (N_POINTS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) bank1 (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (latch & writeBank),
      .wrData (sfft_in),
      .rdEn   (rd_req),
      .rdAddr (rd_addr),
      .rdData (rdData1)
   );

endmodule

// File: tb/tb_sfft_frame_reader.sv
// Directed bench for sfft_frame_reader with an 8-point, 24-bit configuration.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Overwrite-mode scenario is compiled in when SFFT_READER_OVERWRITE_EN is defined.
module tb_sfft_frame_reader;

   localparam int NP = 8;
   localparam int DW = 24;
   localparam int AW = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] sfft_in [NP];
   logic          sfft_valid;
   logic          idle;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          frame_ready;
   logic          frame_ack;
   logic [CW-1:0] frame_count;
   logic [CW-1:0] overrun_count;

   int nPass  = 0;
   int nTotal = 0;
   int idleLows = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] expData;
   } rdVec_t;

   rdVec_t tbl [NP];

   sfft_frame_reader #(
      .N_POINTS   (NP),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sfft_in       (sfft_in),
      .sfft_valid    (sfft_valid),
      .idle          (idle),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .frame_ready   (frame_ready),
      .frame_ack     (frame_ack),
      .frame_count   (frame_count),
      .overrun_count (overrun_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (idle === 1'b0) idleLows++;
   endtask

   task automatic setFrame(input int base);
      for (int k = 0; k < NP; k++) sfft_in[k] = DW'(base + k);
   endtask

   task automatic presentFrame(input int base);
      setFrame(base);
      sfft_valid = 1'b1;
      step();
      step();
      sfft_valid = 1'b0;
      step();
      step();
   endtask

   task automatic ackPulse();
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
   endtask

   task automatic readFrame(input string name, input int base);
      for (int k = 0; k < NP; k++) begin
         rd_req  = 1'b1;
         rd_addr = AW'(k);
         step();
         chk(name, 32'(rd_data), 32'(base + k));
      end
      rd_req = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NP; i++) begin
         tbl[i].addr    = AW'(i);
         tbl[i].expData = DW'(i + 1);
      end

      reset      = 1'b0;
      sfft_valid = 1'b0;
      rd_req     = 1'b0;
      rd_addr    = '0;
      frame_ack  = 1'b0;
      setFrame(0);
      step();
      step();

      // Reset values
      chk("reset idle",          32'(idle), 1);
      chk("reset rd_valid",      32'(rd_valid), 0);
      chk("reset rd_data",       32'(rd_data), 0);
      chk("reset frame_ready",   32'(frame_ready), 0);
      chk("reset frame_count",   32'(frame_count), 0);
      chk("reset overrun_count", 32'(overrun_count), 0);
      reset = 1'b1;
      step();

      // First frame, valid held three cycles: exactly one idle pulse
      setFrame(1);
      idleLows   = 0;
      sfft_valid = 1'b1;
      step();
      step();
      step();
      sfft_valid = 1'b0;
      step();
      step();
      chk("f1 idle pulses", 32'(idleLows), 1);
      chk("f1 frame_count", 32'(frame_count), 1);
      chk("f1 frame_ready", 32'(frame_ready), 1);

      // Back-to-back reads from the vector table
      chk("f1 rd_valid before", 32'(rd_valid), 0);
      for (int i = 0; i < NP; i++) begin
         rd_req  = 1'b1;
         rd_addr = tbl[i].addr;
         step();
         chk("tbl rd_valid", 32'(rd_valid), 1);
         chk("tbl rd_data",  32'(rd_data), 32'(tbl[i].expData));
      end
      rd_req = 1'b0;
      step();
      chk("tbl rd_valid drop", 32'(rd_valid), 0);

      // Release frame, then an ack with nothing ready must change nothing
      ackPulse();
      step();
      chk("ack1 frame_ready", 32'(frame_ready), 0);
      ackPulse();
      step();
      chk("stray ack frame_ready", 32'(frame_ready), 0);
      chk("stray ack frame_count", 32'(frame_count), 1);

      // Two frames without ack: A published, B pending
      presentFrame(0);
      presentFrame(100);
      chk("AB frame_count", 32'(frame_count), 3);
      chk("AB frame_ready", 32'(frame_ready), 1);
      readFrame("A data", 0);

`ifndef SFFT_READER_OVERWRITE_EN
      // Third frame stalls while B is pending
      setFrame(200);
      idleLows   = 0;
      sfft_valid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("stall idle pulses", 32'(idleLows), 0);
      chk("stall frame_count", 32'(frame_count), 3);
      chk("stall overrun",     32'(overrun_count), 0);
      ackPulse();
      chk("ack edge no capture", 32'(frame_count), 3);
      step();
      chk("post-ack capture count", 32'(frame_count), 4);
      chk("post-ack idle low",      32'(idle), 0);
      sfft_valid = 1'b0;
      step();
      step();
      readFrame("B data", 100);
      // Read issued in the swap cycle still sees the old bank
      rd_req    = 1'b1;
      rd_addr   = 3'd2;
      frame_ack = 1'b1;
      step();
      rd_req    = 1'b0;
      frame_ack = 1'b0;
      chk("swap-cycle read", 32'(rd_data), 102);
      chk("swap keeps ready", 32'(frame_ready), 1);
      readFrame("C data", 200);
      ackPulse();
`else
      ackPulse();
      ackPulse();
`endif
      step();
      chk("drained frame_ready", 32'(frame_ready), 0);

      // Same-cycle ack and capture with nothing pending
      presentFrame(300);
      setFrame(400);
      sfft_valid = 1'b1;
      frame_ack  = 1'b1;
      step();
      frame_ack  = 1'b0;
      chk("same-cycle frame_ready", 32'(frame_ready), 1);
      sfft_valid = 1'b0;
      step();
      step();
      readFrame("same-cycle data", 400);
      ackPulse();
      step();
      chk("same-cycle no pending", 32'(frame_ready), 0);
      // Stale read while nothing is ready
      rd_req  = 1'b1;
      rd_addr = 3'd3;
      step();
      rd_req  = 1'b0;
      chk("stale rd_valid", 32'(rd_valid), 1);
      chk("stale rd_data",  32'(rd_data), 403);
      step();

      // Reset the cycle after a latch
      setFrame(500);
      sfft_valid = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("midreset idle",        32'(idle), 1);
      chk("midreset frame_count", 32'(frame_count), 0);
      chk("midreset frame_ready", 32'(frame_ready), 0);
      chk("midreset rd_data",     32'(rd_data), 0);
      step();
      reset = 1'b1;
      step();
      chk("recapture frame_count", 32'(frame_count), 1);
      chk("recapture idle",        32'(idle), 0);
      sfft_valid = 1'b0;
      step();
      step();
      chk("recapture frame_ready", 32'(frame_ready), 1);
      readFrame("recapture data", 500);

`ifdef SFFT_READER_OVERWRITE_EN
      // Three frames, no ack: third replaces the pending second
      ackPulse();
      idleLows = 0;
      presentFrame(600);
      presentFrame(700);
      presentFrame(800);
      chk("ovr idle pulses",   32'(idleLows), 3);
      chk("ovr overrun_count", 32'(overrun_count), 1);
      ackPulse();
      step();
      readFrame("ovr data", 800);
`else
      chk("final overrun_count", 32'(overrun_count), 0);
`endif

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
